// File: rtl/game_config_table.sv
// Loadable per-game configuration table: a fixed-latency linear scan commits the
// config word for the current game. Optional run-time override: GAME_CFG_OVERRIDE_EN.
module game_config_table #(
   parameter int               GAME_W      = 8,
   parameter int               NUM_ENTRIES = 16,
   parameter int               CFG_W       = 8,
   parameter logic [CFG_W-1:0] DEFAULT_CFG = 8'h00,
   // One bit wider than the index so out-of-range addresses can be presented and rejected
   localparam int              ADDR_W      = $clog2(NUM_ENTRIES) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [GAME_W-1:0] game,
   input  logic              tbl_wr,
   input  logic [ADDR_W-1:0] tbl_addr,
   input  logic              tbl_valid,
   input  logic [GAME_W-1:0] tbl_game,
   input  logic [CFG_W-1:0]  tbl_cfg,
`ifdef GAME_CFG_OVERRIDE_EN
   input  logic              ovr_en,
   input  logic [CFG_W-1:0]  ovr_cfg,
`endif
   output logic [CFG_W-1:0]  cfg_word,
   output logic              cfg_valid,
   output logic              cfg_changed,
   output logic              cfg_360pri,
   output logic              cfg_110pcr,
   output logic              cfg_260dar,
   output logic [1:0]        cfg_obj_extender
);

   localparam int               IDX_W    = $clog2(NUM_ENTRIES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   logic [NUM_ENTRIES-1:0] ent_valid_q;
   logic [GAME_W-1:0]      ent_game_q [NUM_ENTRIES];
   logic [CFG_W-1:0]       ent_cfg_q  [NUM_ENTRIES];

   state_t             state_q;
   logic [GAME_W-1:0]  game_q;
   logic               dirty_q;
   logic               dirty_d;
   logic [IDX_W-1:0]   idx_q;
   logic               found_q;
   logic [CFG_W-1:0]   cap_q;
   logic [CFG_W-1:0]   cfg_word_q;
   logic               cfg_valid_q;
   logic               cfg_changed_q;

   logic               wr_ok_s;
   logic [IDX_W-1:0]   wr_idx_s;
   logic               need_scan_s;
   logic               hit_s;
   logic               ovr_chg_s;
   logic [CFG_W-1:0]   commit_cfg_s;

   assign wr_ok_s  = tbl_wr && (tbl_addr < ADDR_W'(NUM_ENTRIES));
   assign wr_idx_s = tbl_addr[IDX_W-1:0];

   // Entry valid bits are the only table state cleared by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         ent_valid_q <= '0;
      end else if (wr_ok_s) begin
         ent_valid_q[wr_idx_s] <= tbl_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_ok_s) begin
         ent_game_q[wr_idx_s] <= tbl_game;
         ent_cfg_q[wr_idx_s]  <= tbl_cfg;
      end
   end

`ifdef GAME_CFG_OVERRIDE_EN
   logic             ovr_en_q;
   logic [CFG_W-1:0] ovr_cfg_q;

   // Previous override inputs, used to detect changes that demand a rescan
   always_ff @(posedge clk) begin
      if (reset) begin
         ovr_en_q  <= 1'b0;
         ovr_cfg_q <= '0;
      end else begin
         ovr_en_q  <= ovr_en;
         ovr_cfg_q <= ovr_cfg;
      end
   end

   assign ovr_chg_s = (ovr_en != ovr_en_q) || (ovr_en && (ovr_cfg != ovr_cfg_q));
`else
   assign ovr_chg_s = 1'b0;
`endif

   always_comb begin
      need_scan_s = (game != game_q) || dirty_q;
      hit_s       = ent_valid_q[idx_q] && (ent_game_q[idx_q] == game_q) && !found_q;

`ifdef GAME_CFG_OVERRIDE_EN
      if (ovr_en) begin
         commit_cfg_s = ovr_cfg;
      end else if (found_q) begin
         commit_cfg_s = cap_q;
      end else begin
         commit_cfg_s = DEFAULT_CFG;
      end
`else
      if (found_q) begin
         commit_cfg_s = cap_q;
      end else begin
         commit_cfg_s = DEFAULT_CFG;
      end
`endif

      // A new write wins over the clear so that no update is ever lost
      dirty_d = dirty_q;
      if (wr_ok_s || ovr_chg_s) begin
         dirty_d = 1'b1;
      end else if (need_scan_s && (state_q != ST_COMMIT)) begin
         dirty_d = 1'b0;
      end else begin
         dirty_d = dirty_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         game_q        <= '0;
         dirty_q       <= 1'b1;
         idx_q         <= '0;
         found_q       <= 1'b0;
         cap_q         <= DEFAULT_CFG;
         cfg_word_q    <= DEFAULT_CFG;
         cfg_valid_q   <= 1'b0;
         cfg_changed_q <= 1'b0;
      end else begin
         dirty_q       <= dirty_d;
         cfg_changed_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (need_scan_s) begin
                  game_q      <= game;
                  idx_q       <= '0;
                  found_q     <= 1'b0;
                  cfg_valid_q <= 1'b0;
                  state_q     <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (need_scan_s) begin
                  game_q  <= game;
                  idx_q   <= '0;
                  found_q <= 1'b0;
               end else begin
                  if (hit_s) begin
                     cap_q   <= ent_cfg_q[idx_q];
                     found_q <= 1'b1;
                  end
                  // Full-depth walk every time keeps the commit latency constant
                  if (idx_q == LAST_IDX) begin
                     state_q <= ST_COMMIT;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            ST_COMMIT: begin
               cfg_word_q    <= commit_cfg_s;
               cfg_valid_q   <= 1'b1;
               cfg_changed_q <= (commit_cfg_s != cfg_word_q);
               state_q       <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cfg_word         = cfg_word_q;
   assign cfg_valid        = cfg_valid_q;
   assign cfg_changed      = cfg_changed_q;
   assign cfg_360pri       = cfg_word_q[0];
   assign cfg_110pcr       = cfg_word_q[1];
   assign cfg_260dar       = cfg_word_q[2];
   assign cfg_obj_extender = cfg_word_q[4:3];

endmodule

// File: tb/tb_game_config_table.sv
// Randomized bench for game_config_table against a table-lookup model with
// commit deadlines derived from the documented latencies.
module tb_game_config_table;

   localparam int N = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] game;
   logic       tbl_wr;
   logic [4:0] tbl_addr;
   logic       tbl_valid;
   logic [7:0] tbl_game;
   logic [7:0] tbl_cfg;
   logic [7:0] cfg_word;
   logic       cfg_valid;
   logic       cfg_changed;
   logic       cfg_360pri;
   logic       cfg_110pcr;
   logic       cfg_260dar;
   logic [1:0] cfg_obj_extender;
`ifdef GAME_CFG_OVERRIDE_EN
   logic       ovr_en;
   logic [7:0] ovr_cfg;
`endif

   always #5 clk = ~clk;

   game_config_table dut (
      .clk              (clk),
      .reset            (reset),
      .game             (game),
      .tbl_wr           (tbl_wr),
      .tbl_addr         (tbl_addr),
      .tbl_valid        (tbl_valid),
      .tbl_game         (tbl_game),
      .tbl_cfg          (tbl_cfg),
`ifdef GAME_CFG_OVERRIDE_EN
      .ovr_en           (ovr_en),
      .ovr_cfg          (ovr_cfg),
`endif
      .cfg_word         (cfg_word),
      .cfg_valid        (cfg_valid),
      .cfg_changed      (cfg_changed),
      .cfg_360pri       (cfg_360pri),
      .cfg_110pcr       (cfg_110pcr),
      .cfg_260dar       (cfg_260dar),
      .cfg_obj_extender (cfg_obj_extender)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int due   = 0;

   bit         m_valid [N];
   logic [7:0] m_game  [N];
   logic [7:0] m_cfg   [N];
   logic [7:0] cur_game;
   logic [7:0] m_word;
`ifdef GAME_CFG_OVERRIDE_EN
   logic       m_ovr_en  = 1'b0;
   logic [7:0] m_ovr_cfg = 8'h00;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] lookup();
`ifdef GAME_CFG_OVERRIDE_EN
      if (m_ovr_en) return m_ovr_cfg;
`endif
      for (int i = 0; i < N; i++) begin
         if (m_valid[i] && m_game[i] == cur_game) return m_cfg[i];
      end
      return 8'h00;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push_due(input int d);
      if (d > due) due = d;
   endtask

   // One clock of stimulus; the model notes which deadline the edge creates
   task automatic apply(input bit wr, input int addr, input bit v, input logic [7:0] g,
                        input logic [7:0] c, input logic [7:0] ng);
      tbl_wr    = wr;
      tbl_addr  = addr[4:0];
      tbl_valid = v;
      tbl_game  = g;
      tbl_cfg   = c;
      game      = ng;
      step();
      tbl_wr = 1'b0;
      if (wr && addr < N) begin
         m_valid[addr] = v;
         m_game[addr]  = g;
         m_cfg[addr]   = c;
         push_due(cyc + N + 2);
      end
      if (ng != cur_game) begin
         cur_game = ng;
         push_due(cyc + N + 1);
      end
   endtask

   task automatic nop();
      apply(1'b0, 0, 1'b0, 8'h00, 8'h00, cur_game);
   endtask

   task automatic settle();
      logic [7:0] exp;
      if (due == 0) begin
         for (int i = 0; i < 20; i++) begin
            step();
            chk("steady_valid", cfg_valid, 1);
            chk("steady_word", cfg_word, m_word);
            chk("steady_changed", cfg_changed, 0);
         end
      end else begin
         while (cyc < due - 1) begin
            step();
            chk("scan_valid_low", cfg_valid, 0);
            chk("scan_word_hold", cfg_word, m_word);
            chk("scan_changed_low", cfg_changed, 0);
         end
         step();
         exp = lookup();
         chk("commit_valid", cfg_valid, 1);
         chk("commit_word", cfg_word, exp);
         chk("commit_changed", cfg_changed, (exp != m_word) ? 1 : 0);
         chk("pri", cfg_360pri, exp[0]);
         chk("pcr", cfg_110pcr, exp[1]);
         chk("dar", cfg_260dar, exp[2]);
         chk("objext", cfg_obj_extender, exp[4:3]);
         m_word = exp;
         step();
         chk("post_valid", cfg_valid, 1);
         chk("post_changed", cfg_changed, 0);
         due = 0;
      end
   endtask

   // Reset with a concurrent write that must be lost
   task automatic do_reset(input int cycles);
      reset     = 1'b1;
      tbl_wr    = 1'b1;
      tbl_addr  = 5'd0;
      tbl_valid = 1'b1;
      tbl_game  = cur_game;
      tbl_cfg   = 8'hAA;
      for (int i = 0; i < cycles; i++) begin
         step();
         chk("rst_valid", cfg_valid, 0);
         chk("rst_word", cfg_word, 8'h00);
         chk("rst_changed", cfg_changed, 0);
      end
      tbl_wr = 1'b0;
      reset  = 1'b0;
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_word = 8'h00;
      due    = cyc + N + 2;
   endtask

   function automatic logic [7:0] pick_game();
      case ($urandom_range(0, 3))
         0:       return 8'h05;
         1:       return 8'h09;
         2:       return cur_game;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      reset     = 1'b1;
      tbl_wr    = 1'b0;
      tbl_addr  = 5'd0;
      tbl_valid = 1'b0;
      tbl_game  = 8'h00;
      tbl_cfg   = 8'h00;
      game      = 8'h05;
      cur_game  = 8'h05;
      m_word    = 8'h00;
`ifdef GAME_CFG_OVERRIDE_EN
      ovr_en  = 1'b0;
      ovr_cfg = 8'h00;
`endif
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0;
         m_game[i]  = 8'h00;
         m_cfg[i]   = 8'h00;
      end

      do_reset(3);
      settle();

      apply(1'b1, 3, 1'b1, 8'h05, 8'h1D, 8'h05);
      settle();

      apply(1'b1, 2, 1'b1, 8'h05, 8'h01, 8'h05);
      apply(1'b1, 7, 1'b1, 8'h05, 8'h02, 8'h05);
      apply(1'b1, 3, 1'b0, 8'h05, 8'h1D, 8'h05);
      settle();
      apply(1'b1, 2, 1'b0, 8'h05, 8'h01, 8'h05);
      settle();

      // Game change part-way through a scan must restart it, with no stale commit
      apply(1'b1, 10, 1'b1, 8'h09, 8'h55, 8'h05);
      repeat (9) nop();
      apply(1'b0, 0, 1'b0, 8'h00, 8'h00, 8'h09);
      chk("restart_deadline", due, cyc + N + 1);
      settle();

      apply(1'b1, 16, 1'b1, 8'h09, 8'hFF, 8'h09);
      apply(1'b1, 31, 1'b1, 8'h09, 8'hEE, 8'h09);
      settle();

      apply(1'b0, 0, 1'b0, 8'h00, 8'h00, 8'h05);
      repeat (5) nop();
      do_reset(1);
      settle();

      for (int it = 0; it < 40; it++) begin
         int len = $urandom_range(1, 6);
         for (int k = 0; k < len; k++) begin
            case ($urandom_range(0, 3))
               0:       apply(1'b1, $urandom_range(0, N - 1), 1'($urandom), pick_game(),
                              8'($urandom), cur_game);
               1:       apply(1'b1, $urandom_range(N, 31), 1'b1, cur_game, 8'($urandom), cur_game);
               2:       apply(1'b0, 0, 1'b0, 8'h00, 8'h00, pick_game());
               default: nop();
            endcase
         end
         settle();
      end

`ifdef GAME_CFG_OVERRIDE_EN
      ovr_en    = 1'b1;
      ovr_cfg   = 8'h04;
      step();
      m_ovr_en  = 1'b1;
      m_ovr_cfg = 8'h04;
      push_due(cyc + N + 2);
      settle();
      ovr_en   = 1'b0;
      step();
      m_ovr_en = 1'b0;
      push_due(cyc + N + 2);
      settle();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
